// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dmem_size_t;

    function automatic logic is_aligned(input dmem_size_t size, input logic [2:0] off);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (off[0] == 1'b0);
            SZ_W:    ok = (off[1:0] == 2'b00);
            SZ_D:    ok = (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 64-bit word: store merge and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  dmem_size_t  size,
    input  logic        is_unsigned,
    input  logic [2:0]  off,
    input  logic [63:0] mem_word,
    input  logic [63:0] wdata,
    output logic [63:0] merged_word,
    output logic [63:0] load_data
);

    logic [7:0]  byte_en;
    logic [63:0] wshift;
    logic [63:0] rshift;
    logic        sext;

    always_comb begin
        byte_en = '0;
        case (size)
            SZ_B:    byte_en = 8'h01;
            SZ_H:    byte_en = 8'h03;
            SZ_W:    byte_en = 8'h0F;
            SZ_D:    byte_en = 8'hFF;
            default: byte_en = 8'h00;
        endcase
        byte_en = byte_en << off;

        wshift      = wdata << {off, 3'b000};
        merged_word = mem_word;
        for (int unsigned i = 0; i < 8; i++) begin
            if (byte_en[i]) merged_word[8*i +: 8] = wshift[8*i +: 8];
        end
    end

    always_comb begin
        rshift    = mem_word >> {off, 3'b000};
        sext      = 1'b0;
        load_data = '0;
        case (size)
            SZ_B: begin
                sext      = ~is_unsigned & rshift[7];
                load_data = {{56{sext}}, rshift[7:0]};
            end
            SZ_H: begin
                sext      = ~is_unsigned & rshift[15];
                load_data = {{48{sext}}, rshift[15:0]};
            end
            SZ_W: begin
                sext      = ~is_unsigned & rshift[31];
                load_data = {{32{sext}}, rshift[31:0]};
            end
            default: load_data = rshift;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Request/response data memory for the MEM stage with configurable wait states.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic            stall
);

  localparam int unsigned     AW         = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] BYTE_SPACE = XLEN'(8 * DEPTH_WORDS);
  localparam logic [3:0]      LAT4       = 4'(LATENCY);

  dmem_state_t     state;
  logic [3:0]      cnt;
  logic            wr_q;
  dmem_size_t      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accept edge, so the live
  // request is used in IDLE and the captured copy everywhere else.
  logic            cur_write;
  dmem_size_t      cur_size;
  logic            cur_uns;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] cur_wdata;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] mem_word;
  logic [XLEN-1:0] merged_word;
  logic [XLEN-1:0] load_data;
  logic            bad;
  logic            enter_resp;
  logic            mem_we;

  always_comb begin
    if (state == IDLE) begin
      cur_write = req_write;
      cur_size  = dmem_size_t'(req_size);
      cur_uns   = req_unsigned;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_write = wr_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    word_idx   = cur_addr[3 +: AW];
    mem_word   = mem[word_idx];
    bad        = !is_aligned(cur_size, cur_addr[2:0]) || (cur_addr >= BYTE_SPACE);
    enter_resp = ((state == IDLE) && req_valid && (LATENCY == 0))
               || ((state == WAIT) && (cnt == 4'd1));
    mem_we     = enter_resp && cur_write && !bad;
    stall      = ((state == IDLE) && req_valid) || (state == WAIT);
  end

  dmem_lane_align u_lane_align (
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .off         (cur_addr[2:0]),
    .mem_word    (mem_word),
    .wdata       (cur_wdata),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= merged_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            size_q    <= dmem_size_t'(req_size);
            uns_q     <= req_unsigned;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT4;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase

      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_error <= bad;
        rsp_rdata <= (bad || cur_write) ? '0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, valid_b;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;

    logic        req_ready_a, rsp_valid_a, rsp_error_a, stall_a;
    logic [63:0] rsp_rdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_error_b, stall_b;
    logic [63:0] rsp_rdata_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
        bit          exp_err;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(64), .DEPTH_WORDS(256), .LATENCY(2), .INIT_FILE("")) dut_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
        .rsp_rdata(rsp_rdata_a), .rsp_error(rsp_error_a), .stall(stall_a)
    );

    dmem_responder #(.XLEN(64), .DEPTH_WORDS(256), .LATENCY(0), .INIT_FILE("")) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
        .rsp_rdata(rsp_rdata_b), .rsp_error(rsp_error_b), .stall(stall_b)
    );

    // Issues one request and waits (bounded) for its response; lat=0 means no response.
    task automatic txn(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output int lat, output logic [63:0] rdata, output logic err,
                       output logic acc_stall, output logic [7:0] stall_mask);
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        #1 acc_stall = sel ? stall_b : stall_a;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        req_write = ~wr; req_size = ~sz; req_addr = ~addr; req_wdata = ~wdata;
        lat = 0; stall_mask = '0; rdata = 'x; err = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i <= 8) stall_mask[i-1] = sel ? stall_b : stall_a;
            if (sel ? rsp_valid_b : rsp_valid_a) begin
                lat   = i;
                rdata = sel ? rsp_rdata_b : rsp_rdata_a;
                err   = sel ? rsp_error_b : rsp_error_a;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req_ready_a, rsp_valid_a, rsp_error_a, stall_a} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl_a got %b expected 1000",
                     {req_ready_a, rsp_valid_a, rsp_error_a, stall_a});
        end
        checks++;
        if (rsp_rdata_a !== 64'h0) begin
            errors++; $display("FAIL reset_rdata_a got %h expected 0", rsp_rdata_a);
        end
        checks++;
        if ({req_ready_b, rsp_valid_b, rsp_error_b, stall_b, rsp_rdata_b} !== {4'b1000, 64'h0}) begin
            errors++;
            $display("FAIL reset_b got %b/%h expected 1000/0",
                     {req_ready_b, rsp_valid_b, rsp_error_b, stall_b}, rsp_rdata_b);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_latency();
        int lat; logic [63:0] rd; logic er, acc; logic [7:0] sm;
        txn(0, 1, 2'd3, 0, 64'h10, 64'h1122334455667788, lat, rd, er, acc, sm);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL sd_latency got %0d expected 3", lat); end
        checks++;
        if ({acc, sm[2:0]} !== 4'b1011) begin
            errors++; $display("FAIL sd_stall got %b expected 1011", {acc, sm[2:0]});
        end
        checks++;
        if ({er, rd} !== {1'b0, 64'h0}) begin
            errors++; $display("FAIL sd_rsp got %b/%h expected 0/0", er, rd);
        end
        txn(0, 0, 2'd3, 0, 64'h10, 64'h0, lat, rd, er, acc, sm);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL ld_latency got %0d expected 3", lat); end
        checks++;
        if ({er, rd} !== {1'b0, 64'h1122334455667788}) begin
            errors++; $display("FAIL ld_rdata got %b/%h expected 0/1122334455667788", er, rd);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid_a, req_ready_a} !== 2'b01) begin
            errors++; $display("FAIL rsp_pulse got %b expected 01", {rsp_valid_a, req_ready_a});
        end
    endtask

    task automatic test_lanes();
        vec_t v[8];
        int lat; logic [63:0] rd; logic er, acc; logic [7:0] sm;
        v = '{
            '{1'b1, 2'd0, 1'b0, 64'h17, 64'h80,  64'h0,                 1'b0},
            '{1'b0, 2'd0, 1'b0, 64'h17, 64'h0,   64'hFFFFFFFFFFFFFF80,  1'b0},
            '{1'b0, 2'd0, 1'b1, 64'h17, 64'h0,   64'h0000000000000080,  1'b0},
            '{1'b0, 2'd1, 1'b0, 64'h16, 64'h0,   64'hFFFFFFFFFFFF8022,  1'b0},
            '{1'b0, 2'd1, 1'b1, 64'h16, 64'h0,   64'h0000000000008022,  1'b0},
            '{1'b0, 2'd2, 1'b0, 64'h14, 64'h0,   64'hFFFFFFFF80223344,  1'b0},
            '{1'b0, 2'd2, 1'b1, 64'h14, 64'h0,   64'h0000000080223344,  1'b0},
            '{1'b0, 2'd3, 1'b1, 64'h10, 64'h0,   64'h8022334455667788,  1'b0}
        };
        foreach (v[i]) begin
            txn(0, v[i].wr, v[i].sz, v[i].uns, v[i].addr, v[i].wdata, lat, rd, er, acc, sm);
            checks++;
            if ({lat == 3, er, rd} !== {1'b1, v[i].exp_err, v[i].exp}) begin
                errors++;
                $display("FAIL lanes[%0d] got lat=%0d err=%b rdata=%h expected lat=3 err=%b rdata=%h",
                         i, lat, er, rd, v[i].exp_err, v[i].exp);
            end
        end
    endtask

    task automatic test_merge();
        vec_t v[5];
        int lat; logic [63:0] rd; logic er, acc; logic [7:0] sm;
        v = '{
            '{1'b1, 2'd0, 1'b0, 64'h13, 64'hDEADBEEFCAFE12AB, 64'h0,                1'b0},
            '{1'b0, 2'd2, 1'b0, 64'h10, 64'h0,               64'hFFFFFFFFAB667788, 1'b0},
            '{1'b0, 2'd3, 1'b0, 64'h10, 64'h0,               64'h80223344AB667788, 1'b0},
            '{1'b0, 2'd0, 1'b1, 64'h12, 64'h0,               64'h0000000000000066, 1'b0},
            '{1'b0, 2'd0, 1'b1, 64'h14, 64'h0,               64'h0000000000000044, 1'b0}
        };
        foreach (v[i]) begin
            txn(0, v[i].wr, v[i].sz, v[i].uns, v[i].addr, v[i].wdata, lat, rd, er, acc, sm);
            checks++;
            if ({lat == 3, er, rd} !== {1'b1, v[i].exp_err, v[i].exp}) begin
                errors++;
                $display("FAIL merge[%0d] got lat=%0d err=%b rdata=%h expected lat=3 err=%b rdata=%h",
                         i, lat, er, rd, v[i].exp_err, v[i].exp);
            end
        end
    endtask

    // Faulting stores must not touch memory; the last in-range word is still usable.
    task automatic test_errors();
        vec_t v[9];
        int lat; logic [63:0] rd; logic er, acc; logic [7:0] sm;
        v = '{
            '{1'b0, 2'd2, 1'b0, 64'h12,  64'h0,               64'h0,                1'b1},
            '{1'b1, 2'd2, 1'b0, 64'h12,  64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1},
            '{1'b1, 2'd1, 1'b0, 64'h11,  64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1},
            '{1'b0, 2'd3, 1'b0, 64'h800, 64'h0,               64'h0,                1'b1},
            '{1'b1, 2'd3, 1'b0, 64'h800, 64'h0102030405060708, 64'h0,                1'b1},
            '{1'b1, 2'd0, 1'b0, 64'h800, 64'h00000000000000FF, 64'h0,                1'b1},
            '{1'b1, 2'd3, 1'b0, 64'h7F8, 64'h0F0E0D0C0B0A0908, 64'h0,                1'b0},
            '{1'b0, 2'd3, 1'b0, 64'h7F8, 64'h0,               64'h0F0E0D0C0B0A0908, 1'b0},
            '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0,               64'h80223344AB667788, 1'b0}
        };
        foreach (v[i]) begin
            txn(0, v[i].wr, v[i].sz, v[i].uns, v[i].addr, v[i].wdata, lat, rd, er, acc, sm);
            checks++;
            if ({lat == 3, er, rd} !== {1'b1, v[i].exp_err, v[i].exp}) begin
                errors++;
                $display("FAIL errors[%0d] got lat=%0d err=%b rdata=%h expected lat=3 err=%b rdata=%h",
                         i, lat, er, rd, v[i].exp_err, v[i].exp);
            end
        end
        txn(0, 0, 2'd3, 0, 64'h0, 64'h0, lat, rd, er, acc, sm);
        checks++;
        if (rd !== 64'h0 && er !== 1'b0) begin
            errors++; $display("FAIL word0_after_oob got err=%b expected 0", er);
        end
    endtask

    task automatic test_zero_latency();
        int lat; logic [63:0] rd; logic er, acc; logic [7:0] sm;
        txn(1, 1, 2'd3, 0, 64'h0, 64'h0123456789ABCDEF, lat, rd, er, acc, sm);
        checks++;
        if ({lat == 1, acc, sm[0], er, rd} !== {3'b110, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL lat0_sd got lat=%0d acc_stall=%b resp_stall=%b err=%b rdata=%h expected lat=1 1 0 0 0",
                     lat, acc, sm[0], er, rd);
        end
        txn(1, 0, 2'd3, 0, 64'h0, 64'h0, lat, rd, er, acc, sm);
        checks++;
        if ({lat == 1, er, rd} !== {2'b10, 64'h0123456789ABCDEF}) begin
            errors++; $display("FAIL lat0_ld got lat=%0d err=%b rdata=%h expected lat=1 0 0123456789ABCDEF",
                               lat, er, rd);
        end
        txn(1, 0, 2'd1, 1, 64'h6, 64'h0, lat, rd, er, acc, sm);
        checks++;
        if ({lat == 1, er, rd} !== {2'b10, 64'h0000000000000123}) begin
            errors++; $display("FAIL lat0_lhu got lat=%0d err=%b rdata=%h expected lat=1 0 123", lat, er, rd);
        end
        @(negedge clk);
        checks++;
        if ({stall_b, rsp_valid_b, req_ready_b} !== 3'b001) begin
            errors++; $display("FAIL lat0_idle got %b expected 001", {stall_b, rsp_valid_b, req_ready_b});
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd; logic er, acc; logic [7:0] sm;
        txn(0, 1, 2'd3, 0, 64'h20, 64'hAAAAAAAAAAAAAAAA, lat, rd, er, acc, sm);
        txn(0, 0, 2'd3, 0, 64'h20, 64'h0, lat, rd, er, acc, sm);
        checks++;
        if (rd !== 64'hAAAAAAAAAAAAAAAA) begin
            errors++; $display("FAIL pre_reset_ld got %h expected AAAAAAAAAAAAAAAA", rd);
        end
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h20; req_wdata = 64'h5555555555555555; valid_a = 1'b1;
        @(posedge clk); #1 valid_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_a, req_ready_a} !== 2'b10) begin
            errors++; $display("FAIL wait_state got %b expected 10", {stall_a, req_ready_a});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready_a, rsp_valid_a, rsp_error_a, stall_a, rsp_rdata_a} !== {4'b1000, 64'h0}) begin
            errors++;
            $display("FAIL mid_reset got %b/%h expected 1000/0",
                     {req_ready_a, rsp_valid_a, rsp_error_a, stall_a}, rsp_rdata_a);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        txn(0, 0, 2'd3, 0, 64'h20, 64'h0, lat, rd, er, acc, sm);
        checks++;
        if ({lat == 3, er, rd} !== {2'b10, 64'hAAAAAAAAAAAAAAAA}) begin
            errors++; $display("FAIL post_reset_ld got lat=%0d err=%b rdata=%h expected lat=3 0 AAAAAAAAAAAAAAAA",
                               lat, er, rd);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_lanes();
        test_merge();
        test_errors();
        test_zero_latency();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
